// File: rtl/burst_sequencer.sv
// ---------------------------------------------------------------------------
// burst_sequencer
//
// Upstream stage of the OOK packet generator in the fan-controller transmit
// path. A command accepted from the UART decoder or the button logic is
// latched onto cmd_out. The block then emits REPEATS single-cycle
// start_packet strobes, one every GAP_CYCLES clocks. After the last strobe it
// stays busy for one trailing gap, so the final packet finishes before the
// next burst can start.
//
// Optional feature (compile-time macro BURST_SEQUENCER_PENDING_EN):
//   Adds a one-deep pending command slot. A request accepted while a burst is
//   running is launched back-to-back when that burst's trailing gap ends,
//   with no IDLE cycle in between. When the macro is undefined, requests are
//   accepted only in IDLE and no pending storage exists.
//
// Handshake: a request transfers on a rising clock edge when req_valid and
//   req_ready are both high in that cycle. req_ready never depends on
//   req_valid. abort forces req_ready low, so a request offered in the same
//   cycle as abort is never taken. A request that is not accepted is ignored;
//   the requester holds it or drops it.
//
// Ports:
//   clk          in   system clock (12 MHz reference domain)
//   reset        in   synchronous, active-high reset
//   req_valid    in   command request present
//   req_cmd      in   [CMD_W-1:0] requested command code
//   req_ready    out  request accepted when high together with req_valid
//   abort        in   synchronous burst cancel; returns to IDLE next cycle
//   cmd_out      out  [CMD_W-1:0] command for the packet generator
//   start_packet out  one-cycle strobe, high exactly in FIRE
//   busy         out  high whenever state != IDLE
//   remaining    out  [CNT_W-1:0] packets of this burst not yet strobed
// ---------------------------------------------------------------------------
module burst_sequencer #(
    parameter int CMD_W      = 3,
    parameter int CMD_RESET  = 7,
    parameter int REPEATS    = 63,
    parameter int CNT_W      = 6,
    parameter int GAP_CYCLES = 131072,
    parameter int GAP_W      = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [CMD_W-1:0] req_cmd,
    output logic             req_ready,
    input  logic             abort,
    output logic [CMD_W-1:0] cmd_out,
    output logic             start_packet,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        GAP  = 2'd2
    } state_t;

    // FIRE lasts one cycle and GAP counts the timer down to zero inclusive,
    // so a reload of GAP_CYCLES-2 gives a FIRE-to-FIRE period of GAP_CYCLES.
    localparam logic [GAP_W-1:0] GAP_RELOAD  = GAP_W'(GAP_CYCLES - 2);
    localparam logic [CNT_W-1:0] REPEATS_VAL = CNT_W'(REPEATS);
    localparam logic [CMD_W-1:0] CMD_RST_VAL = CMD_W'(CMD_RESET);

    state_t           state;
    state_t           state_nx;
    logic [CMD_W-1:0] cmd_q;
    logic [CMD_W-1:0] cmd_nx;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_nx;
    logic [GAP_W-1:0] timer_q;
    logic [GAP_W-1:0] timer_nx;
    logic             accept;

`ifdef BURST_SEQUENCER_PENDING_EN
    logic             pend_valid;
    logic             pend_valid_nx;
    logic [CMD_W-1:0] pend_cmd;
    logic [CMD_W-1:0] pend_cmd_nx;

    // While busy the slot accepts one command as long as it is empty.
    assign req_ready = !abort && ((state == IDLE) || !pend_valid);
`else
    assign req_ready = (state == IDLE) && !abort;
`endif

    assign accept = req_valid && req_ready;

    // Outputs decoded only from registered state.
    assign start_packet = (state == FIRE);
    assign busy         = (state != IDLE);
    assign cmd_out      = cmd_q;
    assign remaining    = rem_q;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cmd_q   <= CMD_RST_VAL;
            rem_q   <= '0;
            timer_q <= '0;
        end else begin
            state   <= state_nx;
            cmd_q   <= cmd_nx;
            rem_q   <= rem_nx;
            timer_q <= timer_nx;
        end
    end

`ifdef BURST_SEQUENCER_PENDING_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_cmd   <= '0;
        end else begin
            pend_valid <= pend_valid_nx;
            pend_cmd   <= pend_cmd_nx;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        cmd_nx   = cmd_q;
        rem_nx   = rem_q;
        timer_nx = timer_q;
`ifdef BURST_SEQUENCER_PENDING_EN
        pend_valid_nx = pend_valid;
        pend_cmd_nx   = pend_cmd;

        // A busy-time accept only happens with the slot empty, so it can
        // never collide with the slot being consumed at the end of a gap.
        if (accept && (state != IDLE)) begin
            pend_valid_nx = 1'b1;
            pend_cmd_nx   = req_cmd;
        end
`endif

        if (abort) begin
            // cmd_out deliberately holds its last value on abort.
            state_nx = IDLE;
            rem_nx   = '0;
            timer_nx = '0;
`ifdef BURST_SEQUENCER_PENDING_EN
            pend_valid_nx = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_nx   = req_cmd;
                        rem_nx   = REPEATS_VAL;
                        state_nx = FIRE;
                    end
                end
                FIRE: begin
                    // FIRE is only entered with rem_q >= 1, so no wrap.
                    rem_nx   = rem_q - 1'b1;
                    timer_nx = GAP_RELOAD;
                    state_nx = GAP;
                end
                GAP: begin
                    if (timer_q != '0) begin
                        timer_nx = timer_q - 1'b1;
                    end else if (rem_q != '0) begin
                        state_nx = FIRE;
                    end else begin
`ifdef BURST_SEQUENCER_PENDING_EN
                        if (pend_valid) begin
                            // Back-to-back launch: no IDLE cycle, so the new
                            // first strobe is GAP_CYCLES after the old last.
                            cmd_nx        = pend_cmd;
                            rem_nx        = REPEATS_VAL;
                            pend_valid_nx = 1'b0;
                            state_nx      = FIRE;
                        end else begin
                            state_nx = IDLE;
                        end
`else
                        state_nx = IDLE;
`endif
                    end
                end
                default: begin
                    state_nx = IDLE;
                    rem_nx   = '0;
                    timer_nx = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_burst_sequencer
//
// Directed bench for burst_sequencer with GAP_CYCLES=8, REPEATS=3, CMD_W=3.
// Each scenario starts from reset; scenario cycle 0 is the first cycle after
// reset is released. Inputs are driven just after the rising edge that opens
// a cycle, and outputs are checked on the falling edge of that cycle.
// Expected strobe cycles are held in an expected queue and popped as they
// occur; all other expectations are hand-written cycle ranges.
// ---------------------------------------------------------------------------
module tb_burst_sequencer;

    localparam int CMD_W      = 3;
    localparam int CMD_RESET  = 7;
    localparam int REPEATS    = 3;
    localparam int CNT_W      = 6;
    localparam int GAP_CYCLES = 8;
    localparam int GAP_W      = 3;

    // clock / reset block
    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic [CMD_W-1:0] req_cmd;
    logic             req_ready;
    logic             abort;
    logic [CMD_W-1:0] cmd_out;
    logic             start_packet;
    logic             busy;
    logic [CNT_W-1:0] remaining;

    always #5 clk = ~clk;

    burst_sequencer #(
        .CMD_W      (CMD_W),
        .CMD_RESET  (CMD_RESET),
        .REPEATS    (REPEATS),
        .CNT_W      (CNT_W),
        .GAP_CYCLES (GAP_CYCLES),
        .GAP_W      (GAP_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_cmd      (req_cmd),
        .req_ready    (req_ready),
        .abort        (abort),
        .cmd_out      (cmd_out),
        .start_packet (start_packet),
        .busy         (busy),
        .remaining    (remaining)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int scn_id = 0;

    // scoreboard: expected strobe cycles of the running scenario
    logic [31:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s scn=%0d cyc=%0d got=%0d exp=%0d",
                     tag, scn_id, cyc, obs, exp);
        end
    endtask

    // remaining for an undisturbed burst whose first strobe is at cycle f
    function automatic int burst_rem(input int f, input int c);
        if (c < f)           return 0;
        else if (c == f)     return 3;
        else if (c <= f + 8) return 2;
        else if (c <= f + 16) return 1;
        else                 return 0;
    endfunction

    // driver tasks
    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_cmd   = '0;
        abort     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive(input int scn, input int c);
        reset     = 1'b0;
        req_valid = 1'b0;
        req_cmd   = '0;
        abort     = 1'b0;
        case (scn)
            0: begin
                if (c == 10) begin req_valid = 1'b1; req_cmd = 3'd2; end
                if (c == 15) begin req_valid = 1'b1; req_cmd = 3'd1; end
            end
            1: begin
                if (c == 10) begin req_valid = 1'b1; req_cmd = 3'd5; end
                if (c == 20) begin
                    req_valid = 1'b1; req_cmd = 3'd6; abort = 1'b1;
                end
            end
            2: begin
                if (c == 10) begin req_valid = 1'b1; req_cmd = 3'd4; end
                if (c == 18) reset = 1'b1;
            end
            default: begin
                if (c == 10) begin req_valid = 1'b1; req_cmd = 3'd0; end
                if (c == 14) begin req_valid = 1'b1; req_cmd = 3'd3; end
            end
        endcase
    endtask

    task automatic run_scn(input int scn, input int last);
        int b_hi;
        int e_cmd;
        int e_rem;
        int e_rdy;
        int e_stb;
        scn_id = scn;
        exp_q.delete();
        case (scn)
            0: begin exp_q = '{32'd11, 32'd19, 32'd27}; b_hi = 34; end
            1: begin exp_q = '{32'd11, 32'd19};         b_hi = 20; end
            2: begin exp_q = '{32'd11};                 b_hi = 18; end
            default: begin
                exp_q = '{32'd11, 32'd19, 32'd27, 32'd35, 32'd43, 32'd51};
                b_hi  = 58;
            end
        endcase
        apply_reset();
        for (int c = 0; c <= last; c++) begin
            cyc = c;
            drive(scn, c);
            @(negedge clk);

            e_stb = 0;
            if (exp_q.size() > 0 && exp_q[0] == c) begin
                e_stb = 1;
                void'(exp_q.pop_front());
            end

            e_cmd = CMD_RESET;
            e_rem = burst_rem(11, c);
            case (scn)
                0: begin
                    if (c >= 11) e_cmd = 2;
                end
                1: begin
                    if (c >= 11) e_cmd = 5;
                    if (c >= 21) e_rem = 0;
                end
                2: begin
                    if (c >= 11 && c <= 18) e_cmd = 4;
                    if (c >= 19) e_rem = 0;
                end
                default: begin
                    if (c >= 11) e_cmd = 0;
                    if (c >= 35) begin e_cmd = 3; e_rem = burst_rem(35, c); end
                end
            endcase

`ifdef BURST_SEQUENCER_PENDING_EN
            case (scn)
                1:       e_rdy = (c == 20) ? 0 : 1;
                3:       e_rdy = (c >= 15 && c <= 34) ? 0 : 1;
                default: e_rdy = 1;
            endcase
`else
            e_rdy = (c >= 11 && c <= b_hi) ? 0 : 1;
            if (scn == 1 && c == 20) e_rdy = 0;
`endif

            check_val("start_packet", 32'(start_packet), 32'(e_stb));
            check_val("busy", 32'(busy), (c >= 11 && c <= b_hi) ? 32'd1 : 32'd0);
            check_val("cmd_out", 32'(cmd_out), 32'(e_cmd));
            check_val("remaining", 32'(remaining), 32'(e_rem));
            check_val("req_ready", 32'(req_ready), 32'(e_rdy));

            @(posedge clk);
            #1;
        end
        check_val("strobes_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
`ifdef BURST_SEQUENCER_PENDING_EN
        run_scn(1, 30);
        run_scn(2, 25);
        run_scn(3, 62);
`else
        run_scn(0, 40);
        run_scn(1, 30);
        run_scn(2, 25);
`endif
        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
